fm_carrier_nco: RTL and testbench

FM_CARRIER_NCO -- requirements
Module: fm_carrier_nco

---
 rtl/fm_carrier_nco.sv | 140 ++++++++++++++
 tb/tb_fm_carrier_nco.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/fm_carrier_nco.sv
// FM carrier NCO: a phase accumulator stepped by a carrier frequency word plus
// a scaled, signed modulation sample. The accumulator only runs once the PLL
// has been locked continuously for a settling interval. Loss of lock sends the
// block back to WAIT_LOCK and clears the accumulator and modulation path.
module fm_carrier_nco #(
  parameter int ACC_WIDTH     = 32,
  parameter int MOD_WIDTH     = 16,
  parameter int DEV_SHIFT     = 4,
  parameter logic [ACC_WIDTH-1:0] CARRIER_WORD = ACC_WIDTH'(32'hE38E38E4),
  parameter int SETTLE_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 pll_locked,
  input  logic [MOD_WIDTH-1:0] mod_data,
  input  logic                 mod_valid,
  output logic                 mod_ready,
  output logic                 rf_out,
  output logic                 wrap,
  output logic                 running
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    SETTLE    = 2'd1,
    RUN       = 2'd2
  } state_t;

  logic [1:0]           r_lock_sync;
  logic                 w_lock_s;
  state_t               r_state;
  state_t               w_state_next;
  logic [CNT_W-1:0]     r_settle_cnt;
  logic [CNT_W-1:0]     w_settle_cnt_next;
  logic                 r_settle_done;
  logic                 w_settle_done_next;
  logic                 w_run_active;
  logic [MOD_WIDTH-1:0] r_mod;
  logic [ACC_WIDTH-1:0] r_freq;
  logic [ACC_WIDTH-1:0] r_acc;
  logic                 r_wrap;
  logic [ACC_WIDTH-1:0] w_mod_ext;
  logic [ACC_WIDTH-1:0] w_mod_dev;
  logic [ACC_WIDTH:0]   w_sum;

  assign w_lock_s = r_lock_sync[1];

  // Two-flop synchronizer for the asynchronous PLL lock indicator.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_lock_sync <= 2'b00;
    end else begin
      r_lock_sync <= {r_lock_sync[0], pll_locked};
    end
  end

  // State, settle counter and settle-done flag registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= WAIT_LOCK;
      r_settle_cnt  <= '0;
      r_settle_done <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_settle_cnt  <= w_settle_cnt_next;
      r_settle_done <= w_settle_done_next;
    end
  end

  // Next-state logic. Loss of lock overrides everything; SETTLE counts down
  // to zero, flags completion, and moves to RUN on the cycle after that.
  always_comb begin
    w_state_next       = r_state;
    w_settle_cnt_next  = r_settle_cnt;
    w_settle_done_next = 1'b0;
    if (!w_lock_s) begin
      w_state_next = WAIT_LOCK;
    end else begin
      case (r_state)
        WAIT_LOCK: begin
          w_state_next      = SETTLE;
          w_settle_cnt_next = SETTLE_LOAD;
        end
        SETTLE: begin
          if (r_settle_done) begin
            w_state_next = RUN;
          end else if (r_settle_cnt == '0) begin
            w_settle_done_next = 1'b1;
          end else begin
            w_settle_cnt_next = r_settle_cnt - CNT_W'(1);
          end
        end
        RUN: begin
          w_state_next = RUN;
        end
        default: begin
          w_state_next = WAIT_LOCK;
        end
      endcase
    end
  end

  // The datapath advances only while the block is in RUN and stays there;
  // the edge that leaves RUN, and every edge outside RUN, clears it.
  assign w_run_active = (r_state == RUN) && w_lock_s;
  assign w_mod_ext    = {{(ACC_WIDTH-MOD_WIDTH){r_mod[MOD_WIDTH-1]}}, r_mod};
  assign w_mod_dev    = w_mod_ext << DEV_SHIFT;
  assign w_sum        = {1'b0, r_acc} + {1'b0, r_freq};

  // Sample capture, frequency word, phase accumulator and carry pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mod  <= '0;
      r_freq <= CARRIER_WORD;
      r_acc  <= '0;
      r_wrap <= 1'b0;
    end else if (w_run_active) begin
      if (mod_valid) begin
        r_mod <= mod_data;
      end
      r_freq <= CARRIER_WORD + w_mod_dev;
      r_acc  <= w_sum[ACC_WIDTH-1:0];
      r_wrap <= w_sum[ACC_WIDTH];
    end else begin
      r_mod  <= '0;
      r_freq <= CARRIER_WORD;
      r_acc  <= '0;
      r_wrap <= 1'b0;
    end
  end

  assign mod_ready = (r_state == RUN);
  assign running   = mod_ready;
  assign rf_out    = r_acc[ACC_WIDTH-1];
  assign wrap      = r_wrap;

endmodule

// File: tb/tb_fm_carrier_nco.sv
// Scoreboard bench for fm_carrier_nco. The stimulus process drives one cycle
// at a time and pushes the expected post-edge state from a behavioural model
// into a queue; a negedge monitor pops and compares against the DUT.
module tb_fm_carrier_nco;
  localparam int          S       = 4;
  localparam logic [31:0] CARRIER = 32'hE38E38E4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        pll_locked;
  logic [15:0] mod_data;
  logic        mod_valid;
  logic        mod_ready;
  logic        rf_out;
  logic        wrap;
  logic        running;

  fm_carrier_nco #(
    .ACC_WIDTH    (32),
    .MOD_WIDTH    (16),
    .DEV_SHIFT    (4),
    .CARRIER_WORD (CARRIER),
    .SETTLE_CYCLES(S)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .pll_locked(pll_locked),
    .mod_data  (mod_data),
    .mod_valid (mod_valid),
    .mod_ready (mod_ready),
    .rf_out    (rf_out),
    .wrap      (wrap),
    .running   (running)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        run;
    logic        rf;
    logic        wr;
    logic [31:0] acc;
    logic [31:0] freq;
    logic [15:0] mdr;
  } exp_t;

  exp_t sb_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  // Behavioural model state. Running is derived from how long the PLL input
  // has been seen high: the block runs after an edge k exactly when the lock
  // input was sampled high on S+2 consecutive edges ending at edge k-2.
  longint      m_acc      = 0;
  longint      m_freq     = longint'(CARRIER);
  logic [15:0] m_mod      = '0;
  logic        m_wrap     = 1'b0;
  bit          m_run_prev = 1'b0;
  int          st_km1     = 0;
  int          st_km2     = 0;

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  task automatic model_edge(input logic rst, input logic pll, input logic vld, input logic [15:0] d);
    exp_t   e;
    bit     run_k;
    bit     active;
    int     newst;
    longint sum;
    if (rst) begin
      st_km1 = 0; st_km2 = 0; m_run_prev = 1'b0;
      m_acc = 0; m_freq = longint'(CARRIER); m_mod = '0; m_wrap = 1'b0;
    end else begin
      newst  = pll ? st_km1 + 1 : 0;
      run_k  = (st_km2 >= S + 2);
      st_km2 = st_km1;
      st_km1 = newst;
      active = m_run_prev && run_k;
      sum    = m_acc + m_freq;
      m_wrap = active && (sum >= 64'h1_0000_0000);
      m_acc  = active ? (sum & 64'hFFFF_FFFF) : 0;
      m_freq = active ? ((longint'(CARRIER) + longint'($signed(m_mod)) * 16) & 64'hFFFF_FFFF)
                      : longint'(CARRIER);
      m_mod  = active ? (vld ? d : m_mod) : 16'h0000;
      m_run_prev = run_k;
    end
    e.run  = m_run_prev;
    e.acc  = m_acc[31:0];
    e.rf   = e.acc[31];
    e.wr   = m_wrap;
    e.freq = m_freq[31:0];
    e.mdr  = m_mod;
    sb_q.push_back(e);
  endtask

  // Drive one cycle of inputs, let the edge happen, then record the expectation.
  task automatic step(input logic rst, input logic pll, input logic vld, input logic [15:0] d);
    reset_n    = ~rst;
    pll_locked = pll;
    mod_valid  = vld;
    mod_data   = d;
    @(posedge clk);
    #1;
    model_edge(rst, pll, vld, d);
  endtask

  // Monitor: one transaction per clock, compared away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      vectors++;
      check("running",   {31'b0, running},   {31'b0, e.run});
      check("mod_ready", {31'b0, mod_ready}, {31'b0, e.run});
      check("rf_out",    {31'b0, rf_out},    {31'b0, e.rf});
      check("wrap",      {31'b0, wrap},      {31'b0, e.wr});
      check("acc",       dut.r_acc,          e.acc);
      check("freq",      dut.r_freq,         e.freq);
      check("mod_r",     {16'b0, dut.r_mod}, {16'b0, e.mdr});
      $display("vec %0d run=%0d acc=%08h freq=%08h mod=%04h wrap=%0d",
               vectors, e.run, e.acc, e.freq, e.mdr, e.wr);
    end
  end

  function automatic logic [15:0] rand_sample();
    case ($urandom_range(0, 3))
      0:       return 16'h8000;
      1:       return 16'h7FFF;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    // Reset held, then lock raised and the settle sequence runs out.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 16'h0000);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b1, 16'h4444);
    for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 1'b1, 16'h5555);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b0, 16'h0000);

    // Directed samples: small positive, most negative, most positive.
    step(1'b0, 1'b1, 1'b1, 16'h0100);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0, 16'hAAAA);
    step(1'b0, 1'b1, 1'b1, 16'h8000);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 16'h0000);
    step(1'b0, 1'b1, 1'b1, 16'h7FFF);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 16'h0000);

    // One-cycle lock drop with a sample on offer throughout, then relock.
    step(1'b0, 1'b0, 1'b1, 16'h1234);
    for (int i = 0; i < 14; i++) step(1'b0, 1'b1, 1'b1, 16'h5678 + 16'(i));

    // Randomized traffic with occasional lock drops.
    for (int i = 0; i < 300; i++)
      step(1'b0, ($urandom_range(0, 59) != 0), 1'($urandom), rand_sample());

    // Settle into RUN, then assert reset between edges.
    for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 1'($urandom), rand_sample());
    @(negedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    vectors++;
    check("async_running", {31'b0, running},   32'd0);
    check("async_ready",   {31'b0, mod_ready}, 32'd0);
    check("async_rf_out",  {31'b0, rf_out},    32'd0);
    check("async_wrap",    {31'b0, wrap},      32'd0);
    check("async_acc",     dut.r_acc,          32'd0);
    check("async_freq",    dut.r_freq,         CARRIER);
    $display("vec %0d async reset run=%0d rf=%0d wrap=%0d", vectors, running, rf_out, wrap);

    for (int i = 0; i < 2; i++) step(1'b1, 1'b1, 1'b0, 16'h0000);
    for (int i = 0; i < 60; i++) step(1'b0, 1'b1, 1'($urandom), rand_sample());

    @(negedge clk);
    #2;
    if (sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
